// File: rtl/grid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grid_pkg
// Description : Shared types and default geometry for the grid frame writer.
//               Holds the FSM state enum, the cell count, the shadow RAM
//               address width and the rgb bus width.
// Revision    : 1.0 - initial release
// ============================================================================
package grid_pkg;

  localparam int c_grid_width  = 20;
  localparam int c_grid_height = 15;
  localparam int c_b_vga       = 4;
  localparam int c_cell_count  = c_grid_width * c_grid_height;
  localparam int c_addr_width  = $clog2(c_cell_count);
  localparam int c_rgb_width   = 3 * c_b_vga;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } grid_state_t;

endpackage
`default_nettype wire

// File: rtl/cell_ram.sv
`default_nettype none
// ============================================================================
// Module      : cell_ram
// Description : Simple dual-port shadow RAM. One write port, one read port
//               with a single registered read stage. Read-first on a
//               same-address collision. Contents are never reset; only the
//               read data register is cleared by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module cell_ram #(
  parameter int DEPTH      = 300,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Storage array: written by the host port, deliberately without reset.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; non-blocking semantics return the pre-write value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= r_mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/grid_frame_writer.sv
`default_nettype none
// ============================================================================
// Module      : grid_frame_writer
// Description : Shadow cell grid for the matrix display. Host logic writes
//               cells at any time; a commit arms a transfer that streams the
//               whole grid in raster order on the next vsync rising edge and
//               ends with a one-cycle update pulse.
//               Optional build macro GRID_FRAME_WRITER_DIRTY_EN: only cells
//               written since their last scan are flagged with cell_en.
// Revision    : 1.0 - initial release
// ============================================================================
module grid_frame_writer
  import grid_pkg::*;
#(
  parameter int GRID_WIDTH  = c_grid_width,
  parameter int GRID_HEIGHT = c_grid_height,
  parameter int B_WIDTH     = 5,
  parameter int B_HEIGHT    = 4,
  parameter int B_VGA       = c_b_vga
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [B_WIDTH-1:0]    wr_x,
  input  logic [B_HEIGHT-1:0]   wr_y,
  input  logic [3*B_VGA-1:0]    wr_rgb,
  input  logic                  commit,
  input  logic                  vsync,
  output logic                  busy,
  output logic                  pending,
  output logic [B_WIDTH-1:0]    cell_x,
  output logic [B_HEIGHT-1:0]   cell_y,
  output logic [3*B_VGA-1:0]    cell_rgb,
  output logic                  cell_en,
  output logic                  update
);

  // Geometry derived from the parameters so non-default grids stay coherent.
  localparam int c_cells = GRID_WIDTH * GRID_HEIGHT;
  localparam int c_aw    = $clog2(c_cells);
  localparam int c_rgbw  = 3 * B_VGA;

  localparam logic [c_aw-1:0]    c_last_addr = c_aw'(c_cells - 1);
  localparam logic [B_WIDTH-1:0] c_last_x    = B_WIDTH'(GRID_WIDTH - 1);

  grid_state_t       r_state;
  grid_state_t       w_state_next;
  logic              w_pending_next;
  logic              r_vsync_q;
  logic              w_vsync_rise;
  logic [c_aw-1:0]   r_scan_addr;
  logic [B_WIDTH-1:0]  r_scan_x;
  logic [B_HEIGHT-1:0] r_scan_y;
  logic              w_wr_ok;
  logic [c_aw-1:0]   w_wr_addr;
  logic              w_scanning;
  logic              w_cell_sel;

  assign w_vsync_rise = vsync & ~r_vsync_q;
  assign w_scanning   = (r_state == SCAN);

  // Out-of-range coordinates would alias onto other cells, so drop them.
  assign w_wr_ok   = wr_en && (int'(wr_x) < GRID_WIDTH) && (int'(wr_y) < GRID_HEIGHT);
  assign w_wr_addr = c_aw'(wr_y) * c_aw'(GRID_WIDTH) + c_aw'(wr_x);

  cell_ram #(
    .DEPTH      (c_cells),
    .ADDR_WIDTH (c_aw),
    .DATA_WIDTH (c_rgbw)
  ) u_cell_ram (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (w_wr_ok),
    .wr_addr (w_wr_addr),
    .wr_data (wr_rgb),
    .rd_en   (w_scanning),
    .rd_addr (r_scan_addr),
    .rd_data (cell_rgb)
  );

`ifdef GRID_FRAME_WRITER_DIRTY_EN
  logic [c_cells-1:0] r_dirty;

  // Dirty flags: cleared as the cell is read, set by writes; a write in the
  // same cycle as the read is assigned last so the flag survives.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dirty <= '0;
    end else begin
      if (w_scanning) begin
        r_dirty[r_scan_addr] <= 1'b0;
      end
      if (w_wr_ok) begin
        r_dirty[w_wr_addr] <= 1'b1;
      end
    end
  end

  assign w_cell_sel = r_dirty[r_scan_addr];
`else
  assign w_cell_sel = 1'b1;
`endif

  // State, sticky pending flag and vsync history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      pending   <= 1'b0;
      r_vsync_q <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      pending   <= w_pending_next;
      r_vsync_q <= vsync;
    end
  end

  // Next-state logic; a commit arriving with the starting edge re-arms.
  always_comb begin
    w_state_next   = r_state;
    w_pending_next = pending;
    case (r_state)
      IDLE:    if (pending) w_state_next = ARMED;
      ARMED:   if (w_vsync_rise) begin
                 w_state_next   = SCAN;
                 w_pending_next = 1'b0;
               end
      SCAN:    if (r_scan_addr == c_last_addr) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    if (commit) begin
      w_pending_next = 1'b1;
    end
  end

  // Raster scan counters; held at zero outside SCAN so every scan starts at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scan_addr <= '0;
      r_scan_x    <= '0;
      r_scan_y    <= '0;
    end else if (w_scanning && (r_scan_addr != c_last_addr)) begin
      r_scan_addr <= r_scan_addr + 1'b1;
      if (r_scan_x == c_last_x) begin
        r_scan_x <= '0;
        r_scan_y <= r_scan_y + 1'b1;
      end else begin
        r_scan_x <= r_scan_x + 1'b1;
      end
    end else begin
      r_scan_addr <= '0;
      r_scan_x    <= '0;
      r_scan_y    <= '0;
    end
  end

  // Registered stream outputs, delayed one cycle to line up with RAM data.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      cell_en <= 1'b0;
      update  <= 1'b0;
      cell_x  <= '0;
      cell_y  <= '0;
    end else begin
      busy    <= (w_state_next == SCAN) || (w_state_next == DONE);
      cell_en <= w_scanning && w_cell_sel;
      update  <= (r_state == DONE);
      if (w_scanning) begin
        cell_x <= r_scan_x;
        cell_y <= r_scan_y;
      end
    end
  end

endmodule
`default_nettype wire
